// File: rtl/divider_seq_n_if.sv
// Request/result bundle between arithmetic-issuing logic and the sequential divider.
// The master issues operands; the slave (divider) returns quotient and remainder.
interface divider_seq_n_if #(
  parameter int nb_bit = 8
);
  logic              start_i;
  logic [nb_bit-1:0] dividend_i;
  logic [nb_bit-1:0] divisor_i;
  logic              ready_o;
  logic              done_o;
  logic [nb_bit-1:0] quotient_o;
  logic [nb_bit-1:0] remainder_o;
  logic              div_by_zero_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  ready_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output ready_o, done_o, quotient_o, remainder_o, div_by_zero_o
  );
endinterface

// File: rtl/divider_seq_n.sv
// Sequential restoring divider: one quotient bit per clock through a single shared
// subtractor_n, with explicit divide-by-zero handling and a one-cycle done pulse.

// subtractor_n: borrow_o=1 means a_i >= b_i (no borrow).
module subtractor_n #(
  parameter int nb_bit = 8
) (
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  output logic [nb_bit-1:0] diff_o,
  output logic              borrow_o
);
  logic [nb_bit:0] wide_diff;

  assign wide_diff = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o    = wide_diff[nb_bit-1:0];
  assign borrow_o  = ~wide_diff[nb_bit];
endmodule

module divider_seq_n #(
  parameter int nb_bit = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  divider_seq_n_if.slave    bus
);
  localparam int CW = $clog2(nb_bit + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [nb_bit-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]     cnt_q;
  logic              zero_q;
  logic [nb_bit-1:0] quotient_q, remainder_q;
  logic              dbz_q;

  logic [nb_bit-1:0] shifted, sub_diff, rem_next, quo_next;
  logic              sub_ok, accept;

  assign shifted = {rem_q[nb_bit-2:0], quo_q[nb_bit-1]};

  subtractor_n #(.nb_bit(nb_bit)) u_sub (
    .a_i      (shifted),
    .b_i      (div_q),
    .diff_o   (sub_diff),
    .borrow_o (sub_ok)
  );

  // A set remainder MSB means the true shifted value exceeds 2^nb_bit, so it always beats D.
  assign accept   = rem_q[nb_bit-1] | sub_ok;
  assign rem_next = accept ? sub_diff : shifted;
  assign quo_next = {quo_q[nb_bit-2:0], accept};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_i) state_next = CALC;
      CALC:    if (cnt_q == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = (state == IDLE);
    bus.done_o  = (state == DONE);
  end

  // A zero divisor still spends one CALC cycle so its done pulse lands one edge after
  // acceptance; zero_q then substitutes the defined all-ones/dividend result.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            rem_q  <= '0;
            quo_q  <= bus.dividend_i;
            div_q  <= bus.divisor_i;
            zero_q <= (bus.divisor_i == '0);
            cnt_q  <= (bus.divisor_i == '0) ? CW'(1) : CW'(nb_bit);
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            dbz_q <= zero_q;
            if (zero_q) begin
              quotient_q  <= '1;
              remainder_q <= quo_q;
            end else begin
              quotient_q  <= quo_next;
              remainder_q <= rem_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient_o    = quotient_q;
  assign bus.remainder_o   = remainder_q;
  assign bus.div_by_zero_o = dbz_q;
endmodule
